lv_ctrl_fsm_mc: RTL and testbench

// - Next-gen LV-side top control FSM: sequences power-up, efuse load, test, normal, failsafe, fault, cfg, reset and BIST.
// - Error sources are a parametrised vector with per-bit class masks, replacing fixed error ports.
// - Adds a BIST timeout, OWT tx request retry with ack timeout, and sticky W1C error status.
// - Sits between the reg bank/SPI/OWT blocks and the PWM/FSC/WDG datapaths.

---
 rtl/lv_ctrl_fsm_mc.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_lv_ctrl_fsm_mc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lv_ctrl_fsm_mc.sv
// LV-side top control FSM: power-up, efuse load, test, normal, failsafe, fault, cfg, reset and BIST sequencing.
// Optional error-input debounce is compiled in with `define LV_FSM_ERR_DBNC_EN.
module lv_ctrl_fsm_mc #(
  parameter int                 ERR_NUM      = 14,
  parameter logic [ERR_NUM-1:0] HARD_MASK    = 14'h3FCF,
  parameter logic [ERR_NUM-1:0] COM_MASK     = 14'h0003,
  parameter int                 BIST_TMO_CYC = 65535,
  parameter int                 ACK_TMO_CYC  = 255,
  parameter int                 RETRY_MAX    = 3,
  parameter int                 DBNC_CYC     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pwr_on,
  input  logic               i_io_test_mode,
  input  logic               i_io_fsenb_n,
  input  logic               i_reg_efuse_vld,
  input  logic               i_reg_efuse_done,
  input  logic               i_reg_nml_en,
  input  logic               i_reg_cfg_en,
  input  logic               i_reg_rst_en,
  input  logic               i_reg_bist_en,
  input  logic [ERR_NUM-1:0] i_err,
  input  logic [ERR_NUM-1:0] i_err_clr,
  output logic               o_efuse_load_req,
  input  logic               i_efuse_load_done,
  output logic               o_owt_tx_req,
  input  logic               i_owt_rx_ack,
  output logic               o_pwm_en,
  output logic               o_fsc_en,
  output logic               o_wdg_scan_en,
  output logic               o_spi_en,
  output logic               o_owt_com_en,
  output logic               o_cfg_st_reg_en,
  output logic               o_test_st_reg_en,
  output logic               o_bist_en,
  output logic               o_intb_n,
  output logic [3:0]         o_fsm_st,
  output logic [ERR_NUM-1:0] o_err_sticky,
  output logic               o_bist_tmo,
  output logic               o_owt_tx_fail
);

  typedef enum logic [3:0] {
    PWR_DWN_ST  = 4'd0,
    WAIT_ST     = 4'd1,
    TEST_ST     = 4'd2,
    NML_ST      = 4'd3,
    FAILSAFE_ST = 4'd4,
    FAULT_ST    = 4'd5,
    CFG_ST      = 4'd6,
    RST_ST      = 4'd7,
    BIST_ST     = 4'd8
  } lv_st_e;

  localparam int BIST_W = $clog2(BIST_TMO_CYC + 1);
  localparam int ACK_W  = $clog2(ACK_TMO_CYC + 1);
  localparam int ATT_W  = $clog2(RETRY_MAX + 1);
  localparam logic [BIST_W-1:0] BIST_LAST = BIST_W'(BIST_TMO_CYC);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TMO_CYC - 1);
  localparam logic [ATT_W-1:0]  ATT_LAST  = ATT_W'(RETRY_MAX - 1);

  lv_st_e              st_r;
  lv_st_e              st_nxt_s;
  logic [ERR_NUM-1:0]  err_s;
  logic                any_s;
  logic                hard_s;
  logic                com_s;
  logic                pd_s;
  logic                bist_tmo_hit_s;
  logic [BIST_W-1:0]   bist_cnt_r;
  logic [ACK_W-1:0]    ack_cnt_r;
  logic [ATT_W-1:0]    att_cnt_r;
  logic                retry_r;
  logic                owt_req_r;
  logic                owt_fail_r;
  logic                efuse_req_r;
  logic                pwm_en_r;
  logic                fsc_en_r;
  logic                wdg_scan_en_r;
  logic                spi_en_r;
  logic                cfg_st_reg_en_r;
  logic                test_st_reg_en_r;
  logic                bist_en_r;
  logic                intb_n_r;
  logic                bist_tmo_r;
  logic [ERR_NUM-1:0]  err_sticky_r;

`ifdef LV_FSM_ERR_DBNC_EN
  localparam int DB_W = $clog2(DBNC_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DBNC_CYC - 1);

  logic [DB_W-1:0] dbnc_cnt_r [ERR_NUM];

  // Per-bit run-length counter of consecutive high raw samples, saturating at DBNC_CYC-1.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < ERR_NUM; i++) begin
      if (i_rst) begin
        dbnc_cnt_r[i] <= {DB_W{1'b0}};
      end else if (!i_err[i]) begin
        dbnc_cnt_r[i] <= {DB_W{1'b0}};
      end else if (dbnc_cnt_r[i] != DB_LAST) begin
        dbnc_cnt_r[i] <= dbnc_cnt_r[i] + DB_W'(1);
      end else begin
        dbnc_cnt_r[i] <= dbnc_cnt_r[i];
      end
    end
  end

  // Filtered error rises on the DBNC_CYC-th high sample and drops with the first low one.
  always_comb begin
    err_s = {ERR_NUM{1'b0}};
    for (int i = 0; i < ERR_NUM; i++) begin
      err_s[i] = i_err[i] && (dbnc_cnt_r[i] == DB_LAST);
    end
  end
`else
  // Transparent filter; an illegal DBNC_CYC of 0 masks every error input.
  assign err_s = i_err & {ERR_NUM{DBNC_CYC > 0}};
`endif

  assign any_s  = |err_s;
  assign hard_s = |(err_s & HARD_MASK);
  assign com_s  = |(err_s & COM_MASK);
  assign pd_s   = (st_r == PWR_DWN_ST) || (st_nxt_s == PWR_DWN_ST);

  // Next-state selection; loss of power overrides every state-local transition.
  always_comb begin
    st_nxt_s       = st_r;
    bist_tmo_hit_s = 1'b0;
    if ((st_r != PWR_DWN_ST) && !i_pwr_on) begin
      st_nxt_s = PWR_DWN_ST;
    end else begin
      case (st_r)
        PWR_DWN_ST: begin
          if (i_pwr_on) st_nxt_s = WAIT_ST;
          else          st_nxt_s = PWR_DWN_ST;
        end
        WAIT_ST: begin
          if (i_io_test_mode || (i_efuse_load_done && !i_reg_efuse_vld))
            st_nxt_s = TEST_ST;
          else if (i_reg_nml_en && i_reg_efuse_vld && !com_s && !i_io_fsenb_n)
            st_nxt_s = FAILSAFE_ST;
          else if (i_reg_nml_en && i_reg_efuse_vld && !com_s)
            st_nxt_s = NML_ST;
          else
            st_nxt_s = WAIT_ST;
        end
        TEST_ST: begin
          if (i_reg_efuse_done && i_reg_efuse_vld) st_nxt_s = WAIT_ST;
          else                                     st_nxt_s = TEST_ST;
        end
        NML_ST: begin
          if (i_reg_cfg_en)                   st_nxt_s = CFG_ST;
          else if (!hard_s && !i_io_fsenb_n)  st_nxt_s = FAILSAFE_ST;
          else if (any_s)                     st_nxt_s = FAULT_ST;
          else                                st_nxt_s = NML_ST;
        end
        FAILSAFE_ST: begin
          if (hard_s)            st_nxt_s = FAULT_ST;
          else if (i_io_fsenb_n) st_nxt_s = NML_ST;
          else                   st_nxt_s = FAILSAFE_ST;
        end
        FAULT_ST: begin
          if (i_reg_cfg_en)                   st_nxt_s = CFG_ST;
          else if (!hard_s && !i_io_fsenb_n)  st_nxt_s = FAILSAFE_ST;
          else if (!any_s && i_io_fsenb_n)    st_nxt_s = NML_ST;
          else                                st_nxt_s = FAULT_ST;
        end
        CFG_ST: begin
          if (i_reg_rst_en)                                   st_nxt_s = RST_ST;
          else if (i_reg_cfg_en)                              st_nxt_s = CFG_ST;
          else if (i_reg_bist_en && !hard_s && i_io_fsenb_n)  st_nxt_s = BIST_ST;
          else if (any_s)                                     st_nxt_s = FAULT_ST;
          else if (!i_io_fsenb_n)                             st_nxt_s = FAILSAFE_ST;
          else                                                st_nxt_s = NML_ST;
        end
        RST_ST: begin
          if (!i_reg_rst_en) st_nxt_s = WAIT_ST;
          else               st_nxt_s = RST_ST;
        end
        BIST_ST: begin
          if (bist_cnt_r == BIST_LAST) begin
            st_nxt_s       = FAULT_ST;
            bist_tmo_hit_s = 1'b1;
          end else if (!i_reg_bist_en) begin
            st_nxt_s = CFG_ST;
          end else begin
            st_nxt_s = BIST_ST;
          end
        end
        default: st_nxt_s = PWR_DWN_ST;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) st_r <= PWR_DWN_ST;
    else       st_r <= st_nxt_s;
  end

  // BIST residency counter: holds the number of cycles spent in BIST including the current one.
  always_ff @(posedge i_clk) begin
    if (i_rst || (st_nxt_s != BIST_ST)) begin
      bist_cnt_r <= {BIST_W{1'b0}};
    end else if (st_r != BIST_ST) begin
      bist_cnt_r <= BIST_W'(1);
    end else begin
      bist_cnt_r <= bist_cnt_r + BIST_W'(1);
    end
  end

  // Datapath enables and interrupt, registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pwm_en_r         <= 1'b0;
      fsc_en_r         <= 1'b0;
      wdg_scan_en_r    <= 1'b0;
      spi_en_r         <= 1'b0;
      cfg_st_reg_en_r  <= 1'b0;
      test_st_reg_en_r <= 1'b0;
      bist_en_r        <= 1'b0;
      intb_n_r         <= 1'b1;
    end else begin
      pwm_en_r         <= (st_nxt_s == NML_ST) || ((st_nxt_s == FAULT_ST) && !hard_s);
      fsc_en_r         <= (st_nxt_s == FAILSAFE_ST);
      wdg_scan_en_r    <= (st_nxt_s == NML_ST) || (st_nxt_s == FAILSAFE_ST) || (st_nxt_s == FAULT_ST);
      spi_en_r         <= (st_nxt_s != PWR_DWN_ST);
      cfg_st_reg_en_r  <= (st_nxt_s == CFG_ST);
      test_st_reg_en_r <= (st_nxt_s == TEST_ST);
      bist_en_r        <= (st_nxt_s == BIST_ST);
      intb_n_r         <= !((st_nxt_s == PWR_DWN_ST) || (st_nxt_s == WAIT_ST) ||
                            (st_nxt_s == FAULT_ST) || (st_nxt_s == RST_ST) ||
                            ((st_nxt_s == CFG_ST) && any_s));
    end
  end

  // Sticky status: W1C on clear, but a same-cycle error keeps the bit set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_sticky_r <= {ERR_NUM{1'b0}};
      bist_tmo_r   <= 1'b0;
    end else begin
      err_sticky_r <= (err_sticky_r & ~i_err_clr) | err_s;
      if (st_nxt_s == PWR_DWN_ST) bist_tmo_r <= 1'b0;
      else if (bist_tmo_hit_s)    bist_tmo_r <= 1'b1;
      else                        bist_tmo_r <= bist_tmo_r;
    end
  end

  // Efuse load request; load_done has priority over a same-cycle set.
  always_ff @(posedge i_clk) begin
    if (i_rst || pd_s) begin
      efuse_req_r <= 1'b0;
    end else if (i_efuse_load_done) begin
      efuse_req_r <= 1'b0;
    end else if ((st_r == WAIT_ST) && !i_io_test_mode && !i_reg_efuse_vld) begin
      efuse_req_r <= 1'b1;
    end else begin
      efuse_req_r <= efuse_req_r;
    end
  end

  // OWT tx request with per-attempt ack timeout, one-cycle low gap between retries, and give-up flag.
  always_ff @(posedge i_clk) begin
    if (i_rst || pd_s) begin
      owt_req_r  <= 1'b0;
      ack_cnt_r  <= {ACK_W{1'b0}};
      att_cnt_r  <= {ATT_W{1'b0}};
      retry_r    <= 1'b0;
      owt_fail_r <= 1'b0;
    end else if (owt_req_r) begin
      if (i_owt_rx_ack) begin
        owt_req_r <= 1'b0;
        ack_cnt_r <= {ACK_W{1'b0}};
        att_cnt_r <= {ATT_W{1'b0}};
      end else if (ack_cnt_r == ACK_LAST) begin
        owt_req_r <= 1'b0;
        ack_cnt_r <= {ACK_W{1'b0}};
        if (att_cnt_r == ATT_LAST) begin
          owt_fail_r <= 1'b1;
          att_cnt_r  <= {ATT_W{1'b0}};
        end else begin
          att_cnt_r <= att_cnt_r + ATT_W'(1);
          retry_r   <= 1'b1;
        end
      end else begin
        ack_cnt_r <= ack_cnt_r + ACK_W'(1);
      end
    end else if (retry_r) begin
      owt_req_r <= 1'b1;
      retry_r   <= 1'b0;
    end else if ((st_r == WAIT_ST) && i_reg_efuse_vld && com_s && !owt_fail_r) begin
      owt_req_r <= 1'b1;
      ack_cnt_r <= {ACK_W{1'b0}};
    end else begin
      owt_req_r <= owt_req_r;
    end
  end

  assign o_fsm_st         = st_r;
  assign o_pwm_en         = pwm_en_r;
  assign o_fsc_en         = fsc_en_r;
  assign o_wdg_scan_en    = wdg_scan_en_r;
  assign o_spi_en         = spi_en_r;
  assign o_owt_com_en     = spi_en_r;
  assign o_cfg_st_reg_en  = cfg_st_reg_en_r;
  assign o_test_st_reg_en = test_st_reg_en_r;
  assign o_bist_en        = bist_en_r;
  assign o_intb_n         = intb_n_r;
  assign o_err_sticky     = err_sticky_r;
  assign o_bist_tmo       = bist_tmo_r;
  assign o_efuse_load_req = efuse_req_r;
  assign o_owt_tx_req     = owt_req_r;
  assign o_owt_tx_fail    = owt_fail_r;

endmodule

// File: tb/tb_lv_ctrl_fsm_mc.sv
// Directed scoreboard bench for lv_ctrl_fsm_mc: expectations queued at stimulus time, checked after the clock edge.
module tb_lv_ctrl_fsm_mc;

  localparam int ERR_NUM = 14;
  localparam int ACK_T   = 4;
  localparam int RETRY   = 3;
  localparam int BIST_T  = 8;
`ifdef LV_FSM_ERR_DBNC_EN
  localparam int PRE = 3;
`else
  localparam int PRE = 0;
`endif

  logic clk = 1'b0;
  logic rst, pwr_on, test_mode, fsenb_n, efuse_vld, efuse_done;
  logic nml_en, cfg_en, rst_en, bist_en, load_done, rx_ack;
  logic [ERR_NUM-1:0] err, err_clr;
  logic efuse_req, owt_req, pwm_en, fsc_en, wdg_en, spi_en, owt_com_en;
  logic cfg_reg_en, test_reg_en, bist_out, intb_n, bist_tmo, tx_fail;
  logic [3:0] fsm_st;
  logic [ERR_NUM-1:0] sticky;

  int vectors = 0;
  int miscompares = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] trace;
  logic [31:0] trace_exp;

  always #5 clk = ~clk;

  lv_ctrl_fsm_mc #(
    .BIST_TMO_CYC(BIST_T), .ACK_TMO_CYC(ACK_T), .RETRY_MAX(RETRY), .DBNC_CYC(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pwr_on(pwr_on), .i_io_test_mode(test_mode),
    .i_io_fsenb_n(fsenb_n), .i_reg_efuse_vld(efuse_vld), .i_reg_efuse_done(efuse_done),
    .i_reg_nml_en(nml_en), .i_reg_cfg_en(cfg_en), .i_reg_rst_en(rst_en), .i_reg_bist_en(bist_en),
    .i_err(err), .i_err_clr(err_clr), .o_efuse_load_req(efuse_req), .i_efuse_load_done(load_done),
    .o_owt_tx_req(owt_req), .i_owt_rx_ack(rx_ack), .o_pwm_en(pwm_en), .o_fsc_en(fsc_en),
    .o_wdg_scan_en(wdg_en), .o_spi_en(spi_en), .o_owt_com_en(owt_com_en),
    .o_cfg_st_reg_en(cfg_reg_en), .o_test_st_reg_en(test_reg_en), .o_bist_en(bist_out),
    .o_intb_n(intb_n), .o_fsm_st(fsm_st), .o_err_sticky(sticky), .o_bist_tmo(bist_tmo),
    .o_owt_tx_fail(tx_fail)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; pwr_on = 1'b0; test_mode = 1'b0; fsenb_n = 1'b0; efuse_vld = 1'b0;
    efuse_done = 1'b0; nml_en = 1'b0; cfg_en = 1'b0; rst_en = 1'b0; bist_en = 1'b0;
    load_done = 1'b0; rx_ack = 1'b0; err = '0; err_clr = '0;
    tick(2);
    expect_v("rst_st", 32'd0); expect_v("rst_intb", 32'd1); expect_v("rst_pwm", 32'd0);
    expect_v("rst_spi", 32'd0); expect_v("rst_sticky", 32'd0); expect_v("rst_owt", 32'd0);
    observe(32'(fsm_st)); observe(32'(intb_n)); observe(32'(pwm_en));
    observe(32'(spi_en)); observe(32'(sticky)); observe(32'(owt_req));

    // Power up into WAIT then NML.
    rst = 1'b0; pwr_on = 1'b1; efuse_vld = 1'b1; nml_en = 1'b1; fsenb_n = 1'b1;
    expect_v("wait_st", 32'd1); expect_v("wait_pwm", 32'd0); expect_v("wait_intb", 32'd0);
    expect_v("wait_owtcom", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(pwm_en)); observe(32'(intb_n)); observe(32'(owt_com_en));
    expect_v("nml_st", 32'd3); expect_v("nml_pwm", 32'd1); expect_v("nml_intb", 32'd1);
    expect_v("nml_wdg", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(pwm_en)); observe(32'(intb_n)); observe(32'(wdg_en));

`ifdef LV_FSM_ERR_DBNC_EN
    err = 14'h0010;
    expect_v("dbnc_glitch_st", 32'd3);
    tick(3);
    observe(32'(fsm_st));
    err = 14'h0000;
    tick(1);
    err = 14'h0010;
    expect_v("dbnc_pre_st", 32'd3);
    tick(3);
    observe(32'(fsm_st));
    expect_v("dbnc_fault_st", 32'd5);
    tick(1);
    observe(32'(fsm_st));
    err = 14'h0000;
    expect_v("dbnc_back_st", 32'd3);
    tick(1);
    observe(32'(fsm_st));
    err_clr = 14'h0010;
    tick(1);
    err_clr = 14'h0000;
`endif

    // Hard error pulse from NML.
    err = 14'h0004;
    tick(PRE);
    expect_v("hard_st", 32'd5); expect_v("hard_pwm", 32'd0); expect_v("hard_intb", 32'd0);
    expect_v("hard_sticky", 32'h4);
    tick(1);
    observe(32'(fsm_st)); observe(32'(pwm_en)); observe(32'(intb_n)); observe(32'(sticky));
    err_clr = 14'h0004;
    expect_v("setwins_st", 32'd5); expect_v("setwins_sticky", 32'h4);
    tick(1);
    observe(32'(fsm_st)); observe(32'(sticky));
    err = 14'h0000;
    expect_v("clr_st", 32'd3); expect_v("clr_sticky", 32'h0); expect_v("clr_pwm", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(sticky)); observe(32'(pwm_en));
    err_clr = 14'h0000;

    // Soft error keeps PWM running in FAULT.
    err = 14'h0010;
    tick(PRE);
    expect_v("soft_st", 32'd5); expect_v("soft_pwm", 32'd1); expect_v("soft_intb", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(pwm_en)); observe(32'(intb_n));
    err = 14'h0000; err_clr = 14'h0010;
    expect_v("soft_back_st", 32'd3);
    tick(1);
    observe(32'(fsm_st));
    err_clr = 14'h0000;

    // Failsafe pin round trip.
    fsenb_n = 1'b0;
    expect_v("fs_st", 32'd4); expect_v("fs_fsc", 32'd1); expect_v("fs_pwm", 32'd0);
    expect_v("fs_intb", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(fsc_en)); observe(32'(pwm_en)); observe(32'(intb_n));
    fsenb_n = 1'b1;
    expect_v("fs_back_st", 32'd3); expect_v("fs_back_fsc", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(fsc_en));

    // CFG -> BIST held until timeout.
    cfg_en = 1'b1;
    expect_v("cfg_st", 32'd6); expect_v("cfg_reg", 32'd1); expect_v("cfg_intb", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(cfg_reg_en)); observe(32'(intb_n));
    cfg_en = 1'b0; bist_en = 1'b1;
    expect_v("bist_st", 32'd8); expect_v("bist_out", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(bist_out));
    expect_v("bist_last_st", 32'd8); expect_v("bist_last_tmo", 32'd0);
    tick(BIST_T - 1);
    observe(32'(fsm_st)); observe(32'(bist_tmo));
    expect_v("bist_tmo_st", 32'd5); expect_v("bist_tmo_flag", 32'd1); expect_v("bist_tmo_out", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(bist_tmo)); observe(32'(bist_out));
    bist_en = 1'b0;
    expect_v("tmo_nml_st", 32'd3); expect_v("tmo_sticky", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(bist_tmo));

    // CFG -> RST -> WAIT -> NML.
    cfg_en = 1'b1;
    expect_v("cfg2_st", 32'd6);
    tick(1);
    observe(32'(fsm_st));
    rst_en = 1'b1;
    expect_v("rst_st7", 32'd7); expect_v("rst_intb0", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(intb_n));
    rst_en = 1'b0; cfg_en = 1'b0;
    expect_v("rst_wait_st", 32'd1);
    tick(1);
    observe(32'(fsm_st));
    expect_v("rst_nml_st", 32'd3);
    tick(1);
    observe(32'(fsm_st));

    // BIST timer restarts on re-entry; power loss mid-BIST.
    cfg_en = 1'b1;
    tick(1);
    cfg_en = 1'b0; bist_en = 1'b1;
    tick(3);
    bist_en = 1'b0;
    expect_v("bist_exit_st", 32'd6);
    tick(1);
    observe(32'(fsm_st));
    bist_en = 1'b1;
    expect_v("bist_reent_st", 32'd8);
    tick(BIST_T);
    observe(32'(fsm_st));
    pwr_on = 1'b0; bist_en = 1'b0;
    expect_v("pd_st", 32'd0); expect_v("pd_tmo", 32'd0); expect_v("pd_spi", 32'd0);
    expect_v("pd_intb", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(bist_tmo)); observe(32'(spi_en)); observe(32'(intb_n));

    // Efuse load handshake.
    efuse_vld = 1'b0; nml_en = 1'b0; pwr_on = 1'b1;
    expect_v("ef_wait_st", 32'd1); expect_v("ef_req0", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(efuse_req));
    expect_v("ef_req1", 32'd1);
    tick(1);
    observe(32'(efuse_req));
    load_done = 1'b1;
    expect_v("ef_test_st", 32'd2); expect_v("ef_req_done", 32'd0); expect_v("ef_test_reg", 32'd1);
    tick(1);
    observe(32'(fsm_st)); observe(32'(efuse_req)); observe(32'(test_reg_en));
    load_done = 1'b0; efuse_vld = 1'b1; efuse_done = 1'b1;
    expect_v("ef_back_st", 32'd1); expect_v("ef_test_reg0", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(test_reg_en));
    efuse_done = 1'b0;

    // OWT retries without ack, then give up.
    err = 14'h0001;
    tick(PRE);
    trace_exp = '0;
    for (int i = 0; i < 20; i++) begin
      trace_exp[i] = (i < RETRY * (ACK_T + 1)) && ((i % (ACK_T + 1)) != ACK_T);
    end
    expect_v("owt_trace", trace_exp); expect_v("owt_fail", 32'd1);
    trace = '0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      trace[i] = owt_req;
    end
    observe(trace); observe(32'(tx_fail));

    // Power cycle clears the failure; ack on the timeout cycle is a success.
    pwr_on = 1'b0;
    expect_v("owt_pd_st", 32'd0); expect_v("owt_pd_fail", 32'd0);
    tick(1);
    observe(32'(fsm_st)); observe(32'(tx_fail));
    pwr_on = 1'b1;
    tick(1);
    expect_v("owt_req_set", 32'd1);
    tick(1);
    observe(32'(owt_req));
    expect_v("owt_req_held", 32'd1);
    tick(ACK_T - 1);
    observe(32'(owt_req));
    rx_ack = 1'b1; err = 14'h0000;
    expect_v("owt_ack_req", 32'd0); expect_v("owt_ack_fail", 32'd0);
    tick(1);
    observe(32'(owt_req)); observe(32'(tx_fail));
    rx_ack = 1'b0;
    expect_v("owt_no_retry", 32'd0);
    tick(1);
    observe(32'(owt_req));

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
